// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz timing constants, painter colours and a decode helper
// for the VGA display path.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hfff;

    // True when v lies in [lo, lo+len-1].
    function automatic logic in_span(input logic [9:0] v, input int unsigned lo,
                                     input int unsigned len);
        return ({22'd0, v} >= lo) && ({22'd0, v} < lo + len);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock into a one-clk pixel-rate enable; the first tick
// is seen on the CLK_DIV-th clock after reset release.
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick       = (tick_cnt_q == LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_cnt_q <= '0;
        else       tick_cnt_q <= tick_cnt_d;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA display timing: horizontal/vertical counters with registered position,
// blanking, sync and line/frame strobes, all updated on the pixel tick.
module vga_timing_gen
    import vga_timing_pkg::in_span;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       vid_on,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       pix_tick,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic       tick;
    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [9:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic       vid_on_q, vid_on_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic       pix_tick_q, pix_tick_d, line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       h_wrap, v_wrap;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Outputs decode the pre-increment counters, so the first tick shows (0,0).
    always_comb begin
        h_wrap        = (h_cnt_q == 10'(H_TOT - 1));
        v_wrap        = (v_cnt_q == 10'(V_TOT - 1));
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        vid_on_d      = vid_on_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        pix_tick_d    = tick;
        line_start_d  = tick && (h_cnt_q == '0);
        frame_start_d = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
        if (tick) begin
            h_cnt_d   = h_wrap ? '0 : h_cnt_q + 10'd1;
            if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
            pixel_x_d = h_cnt_q;
            pixel_y_d = v_cnt_q;
            vid_on_d  = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
            hsync_d   = in_span(h_cnt_q, H_ACTIVE + H_FP, H_SYNC) ? SYNC_ON : SYNC_OFF;
            vsync_d   = in_span(v_cnt_q, V_ACTIVE + V_FP, V_SYNC) ? SYNC_ON : SYNC_OFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            vid_on_q      <= 1'b0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            vid_on_q      <= vid_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_tick_q    <= pix_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign vid_on      = vid_on_q;
    assign horiz_sync  = hsync_q;
    assign vert_sync   = vsync_q;
    assign pix_tick    = pix_tick_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default 640x480 build plus reduced-geometry
// builds at CLK_DIV=4 and CLK_DIV=1 so frame wraps are reachable quickly.
module tb_vga_timing_gen;

    typedef logic [25:0] obs_t; // {x[10], y[10], vid, hs, vs, tick, line, frame}

    localparam obs_t RST_VAL = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3'b000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_edge   = 0;

    obs_t q_d[$], q_s[$], q_1[$];

    logic [9:0] px_d, py_d, px_s, py_s, px_1, py_1;
    logic vid_d, hs_d, vs_d, pt_d, ls_d, fs_d;
    logic vid_s, hs_s, vs_s, pt_s, ls_s, fs_s;
    logic vid_1, hs_1, vs_1, pt_1, ls_1, fs_1;

    vga_timing_gen #(.CLK_DIV(4)) dut_d (
        .clk(clk), .reset(rst), .pixel_x(px_d), .pixel_y(py_d), .vid_on(vid_d),
        .horiz_sync(hs_d), .vert_sync(vs_d), .pix_tick(pt_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_s (
        .clk(clk), .reset(rst), .pixel_x(px_s), .pixel_y(py_s), .vid_on(vid_s),
        .horiz_sync(hs_s), .vert_sync(vs_s), .pix_tick(pt_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_1 (
        .clk(clk), .reset(rst), .pixel_x(px_1), .pixel_y(py_1), .vid_on(vid_1),
        .horiz_sync(hs_1), .vert_sync(vs_1), .pix_tick(pt_1),
        .line_start(ls_1), .frame_start(fs_1)
    );

    obs_t obs_d, obs_s, obs_1;
    assign obs_d = {px_d, py_d, vid_d, hs_d, vs_d, pt_d, ls_d, fs_d};
    assign obs_s = {px_s, py_s, vid_s, hs_s, vs_s, pt_s, ls_s, fs_s};
    assign obs_1 = {px_1, py_1, vid_1, hs_1, vs_1, pt_1, ls_1, fs_1};

    // Closed-form expectation after clock edge n following reset release (n=0 in reset).
    function automatic obs_t model(input int unsigned n, input int unsigned d,
                                   input int unsigned ha, input int unsigned hfp,
                                   input int unsigned hs, input int unsigned hbp,
                                   input int unsigned va, input int unsigned vfp,
                                   input int unsigned vs, input int unsigned vbp);
        int unsigned ht, vt, p, x, y;
        logic first, vid, hsy, vsy;
        if (n < d) return RST_VAL;
        ht    = ha + hfp + hs + hbp;
        vt    = va + vfp + vs + vbp;
        p     = n / d - 1;
        x     = p % ht;
        y     = (p / ht) % vt;
        first = (n % d == 0);
        vid   = (x < ha) && (y < va);
        hsy   = !((x >= ha + hfp) && (x < ha + hfp + hs));
        vsy   = !((y >= va + vfp) && (y < va + vfp + vs));
        return {10'(x), 10'(y), vid, hsy, vsy, first, first && (x == 0),
                first && (x == 0) && (y == 0)};
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    endtask

    always @(posedge clk) begin
        if (rst) n_edge = 0;
        else     n_edge++;
        q_d.push_back(model(n_edge, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        q_s.push_back(model(n_edge, 4, 8, 2, 3, 2, 6, 1, 2, 1));
        q_1.push_back(model(n_edge, 1, 8, 2, 3, 2, 6, 1, 2, 1));
    end

    always @(negedge clk) begin
        if (q_d.size() != 0) check("dut_d", obs_d, q_d.pop_front());
        if (q_s.size() != 0) check("dut_s", obs_s, q_s.pop_front());
        if (q_1.size() != 0) check("dut_1", obs_1, q_1.pop_front());
    end

    initial begin
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (7000) @(negedge clk);
        // Async reset partway through a pixel hold: outputs must clear before the next edge.
        @(posedge clk);
        #2;
        rst = 1'b1;
        q_d.delete();
        q_s.delete();
        q_1.delete();
        #1;
        check("async_rst_d", obs_d, RST_VAL);
        check("async_rst_s", obs_s, RST_VAL);
        check("async_rst_1", obs_1, RST_VAL);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3000) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display timing generator for the 640x480 @ 60 Hz VGA path.
- Divides the system clock into a pixel-rate enable and runs horizontal/vertical counters.
- Produces registered pixel_x, pixel_y and vid_on, which feed the screen painter directly downstream.
- Also drives the monitor sync pins and line/frame strobes for the tile/icon fetch logic.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, sync asserted level (0 = active-low, the 640x480 standard).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- vid_on  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
- horiz_sync  out  1  horizontal sync, level per SYNC_POL.
- vert_sync  out  1  vertical sync, level per SYNC_POL.
- pix_tick  out  1  one-clk strobe on the first clk of each new output pixel.
- line_start  out  1  equals pix_tick AND pixel_x == 0.
- frame_start  out  1  equals pix_tick AND pixel_x == 0 AND pixel_y == 0.

Behaviour:
- Derived constants: H_TOTAL = sum of H_* (default 800); V_TOTAL = sum of V_* (default 525). Both must be <= 1024.
- Reset is asynchronous and active-high, one clock domain: clk.
- Reset values: internal counters 0; pixel_x = 0; pixel_y = 0; vid_on = 0; pix_tick = 0; line_start = 0; frame_start = 0; both syncs at the deasserted level (~SYNC_POL).
- Divider: tick_cnt counts 0..CLK_DIV-1 and wraps.
  - Internal tick is high when tick_cnt == CLK_DIV-1.
  - With CLK_DIV = 1 the internal tick is high every clk.
  - The first tick occurs on the CLK_DIV-th clk edge after reset deasserts.
- Counters h_cnt/v_cnt advance only on an internal tick.
  - h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt increments on each h wrap and wraps from V_TOTAL-1 to 0 on the h wrap at the end of the last line.
- Output registers load only on an internal tick, from the decode of the pre-increment counters. Counters advance on the same edge.
- Consequences of this loading rule:
  - The first post-reset tick presents (0,0) with frame_start = 1.
  - Every output pixel is held for exactly CLK_DIV clks.
  - pix_tick, line_start and frame_start are high only during the first clk of that hold.
- All outputs are mutually aligned; there is no skew between position, vid_on and syncs.
- horiz_sync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
- vert_sync is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, across all h of those lines.
- Blanking: pixel_x/pixel_y keep counting through blanking (never clamped); vid_on = 0 there.
- Reset asserted mid-frame: all outputs return to reset values immediately. Counting restarts at (0,0) after deassertion, with first-tick timing as above.
- No other inputs exist; the block free-runs. There are no backpressure or stall conditions.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 default constants (H_ACTIVE .. V_BP, H_TOTAL, V_TOTAL);
  - colour constants BLACK/WHITE, shared with the screen painter.
- Sub-module pixel_tick_gen (parameter CLK_DIV; ports clk, reset, tick) isolates the divider.
- Counters, decode and output registers stay in vga_timing_gen.

Test Plan:
- Reset hold then release, CLK_DIV=4:
  - All outputs hold reset values while reset is high.
  - On clk edge 4 after release: pixel_x=0, pixel_y=0, vid_on=1, pix_tick=1, frame_start=1.
  - pixel_x=1 appears exactly 4 clks later.
- Horizontal timing, CLK_DIV=4:
  - horiz_sync low for exactly 384 clks, starting when pixel_x becomes 656.
  - line_start period is 3200 clks.
  - vid_on high for 2560 consecutive clks per visible line.
- Vertical timing, CLK_DIV=4:
  - frame_start period is 1,680,000 clks.
  - vert_sync low for exactly 1600 pix_ticks (lines 490-491).
  - 480 lines contain any vid_on.
- Wrap: at (799,524) the next pixel is (0,0) with frame_start=1; at (799,10) the next pixel is (0,11) with line_start=1.
- CLK_DIV=1 build: pix_tick is high every clk and pixel_x increments every clk; frame period is 420,000 clks.
- Async reset asserted at pixel (300,200) mid-hold: outputs go to reset values before the next clk edge; after release, (0,0) is presented on clk edge 4.
